ctr_seg7_scan: RTL
==================

CTR_SEG7_SCAN -- requirements
Module: ctr_seg7_scan

Interface
REQ-001 The block SHALL have parameter PRESCALE_WIDTH, default 16: width of the scan prescaler, so one digit advance occurs every 2^PRESCALE_WIDTH cycles.
REQ-002 The block SHALL have port clk, input, 1 bit: single clock; all state updates on its rising edge.
REQ-003 The block SHALL have port rst, input, 1 bit: reset, synchronous and active-high.
REQ-004 The block SHALL have port x, input, 4 bits: count value from the upstream 4-bit counter, sampled every cycle.
REQ-005 The block SHALL have port seg, output, 7 bits: segment drive, with seg[0]=a through seg[6]=g.
REQ-006 The block SHALL have port an, output, 4 bits: digit enable, one-hot, with an[0] as the rightmost digit.

Function
REQ-007 The prescaler SHALL increment every cycle, wrap from all-ones to 0, and assert an internal tick for exactly the one cycle in which it holds all-ones.
REQ-008 A 2-bit scan index sel SHALL advance 0->1->2->3->0 on each tick and hold otherwise.
REQ-009 History registers h0..h3 (4 bits each) with valid bits v0..v3 SHALL form a 4-deep change log.
REQ-010 A change is detected in a cycle when x differs from h0; on that cycle h3<=h2, h2<=h1, h1<=h0, h0<=x, and v likewise shifts with v0<=1.
REQ-011 When x equals h0, the history and valid bits SHALL hold.
REQ-012 seg and an SHALL be registered: in cycle n+1 they reflect sel, h[sel] and v[sel] as they stand after the updates of cycle n, giving one cycle of output latency.
REQ-013 an SHALL be one-hot at bit sel.
REQ-014 seg SHALL be the hex decode of h[sel]: 0=3F 1=06 2=5B 3=4F 4=66 5=6D 6=7D 7=07 8=7F 9=6F A=77 b=7C C=39 d=5E E=79 F=71.
REQ-015 A digit with v[sel]=0 SHALL be blanked, with seg=00 while an still selects that digit.
REQ-016 When a tick and a change occur in the same cycle, both SHALL take effect, and the next-cycle outputs use the new sel and the shifted history.
REQ-017 Upstream wrap-around (F->0 or 0->F) SHALL be treated as an ordinary change, with no special case.
REQ-018 After four or more changes all digits are valid; older entries are discarded from h3.

Reset
REQ-019 With rst high at a clock edge, the block SHALL clear the prescaler to 0, sel to 0, h0..h3 to 0, and set v to 0001.
REQ-020 With rst high at a clock edge, the block SHALL drive an=0001 and seg=3F.
REQ-021 Reset SHALL take priority over tick and change detection in the same cycle.
REQ-022 Reset asserted mid-scan or mid-history SHALL discard all state, with no partial retention.
REQ-023 The first change after reset SHALL compare x against h0=0.

Configuration
REQ-024 With macro SEG7_ACTIVE_LOW_EN defined, seg and an SHALL both be bitwise inverted at the output registers, including reset values (an=1110, seg=40) and blanking (seg=7F).
REQ-025 Without SEG7_ACTIVE_LOW_EN, seg and an SHALL be active-high as specified above.
REQ-026 Internal state and timing SHALL be identical in both builds.

Structure
REQ-027 The shared package ctr_pkg SHALL hold the 16-entry hex-to-segment constant table, the digit count (4), and the count width (4).
REQ-028 The hex-to-7-segment decode SHALL be one combinational sub-module, seg7_decode (4-bit in, 7-bit out, active-high), instantiated once on the selected digit.
REQ-029 Prescaler, scan index, history and output registers SHALL reside in ctr_seg7_scan.

Verification (benches use PRESCALE_WIDTH=2, so a tick occurs every 4 cycles)
REQ-030 Reset test: hold rst 2 cycles with x=0 -> an=0001, seg=3F; digits 1-3 show seg=00 when scanned.
REQ-031 History test: drive x=1,2,3,4, each held 8 cycles -> after a full scan, digits 0..3 show 66,4F,5B,06.
REQ-032 Simultaneous tick and change: change x on the tick cycle -> the next cycle shows an advanced and the new history value on the newly selected digit, with no glitch cycle.
REQ-033 Wrap and hold test: x steps F->0, then holds 0 for 20 cycles -> exactly one shift, h0=0, h1=F (seg 71 on digit 1), no further shifts.
REQ-034 Mid-operation reset: assert rst while sel=2 with full history -> the next cycle shows an=0001, seg=3F, and digits 1-3 are blanked.
REQ-035 Polarity build: with SEG7_ACTIVE_LOW_EN, rerun REQ-030 and REQ-031 -> every output equals the bitwise inverse of the active-high build, cycle for cycle.

Source files
------------

// File: rtl/ctr_pkg.sv
// Shared constants for the counter scan display: digit count, count width and hex-to-segment table.
package ctr_pkg;

    localparam int DIGITS  = 4;
    localparam int COUNT_W = 4;

    typedef logic [COUNT_W-1:0] count_t;
    typedef logic [6:0]         seg_t;

    // Active-high segment patterns, seg[0]=a .. seg[6]=g, indexed by hex value.
    localparam logic [0:15][6:0] SEG_TABLE = {
        7'h3F, 7'h06, 7'h5B, 7'h4F,
        7'h66, 7'h6D, 7'h7D, 7'h07,
        7'h7F, 7'h6F, 7'h77, 7'h7C,
        7'h39, 7'h5E, 7'h79, 7'h71
    };

endpackage

// File: rtl/seg7_decode.sv
// Combinational hex to 7-segment decoder, active-high outputs.
module seg7_decode
    import ctr_pkg::*;
(
    input  logic [COUNT_W-1:0] hex,
    output logic [6:0]         seg
);

    assign seg = SEG_TABLE[hex];

endmodule

// File: rtl/ctr_seg7_scan.sv
// Scanned 4-digit display of the last four distinct counter values.
// Build option: define SEG7_ACTIVE_LOW_EN for inverted (active-low) seg and an outputs.
module ctr_seg7_scan
    import ctr_pkg::*;
#(
    parameter int PRESCALE_WIDTH = 16
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [COUNT_W-1:0] x,
    output logic [6:0]         seg,
    output logic [DIGITS-1:0]  an
);

`ifdef SEG7_ACTIVE_LOW_EN
    localparam logic [6:0]        SEG_POL = 7'h7F;
    localparam logic [DIGITS-1:0] AN_POL  = '1;
`else
    localparam logic [6:0]        SEG_POL = 7'h00;
    localparam logic [DIGITS-1:0] AN_POL  = '0;
`endif

    logic [PRESCALE_WIDTH-1:0]        cnt;
    logic [1:0]                       sel;
    logic [DIGITS-1:0][COUNT_W-1:0]   h;
    logic [DIGITS-1:0]                v;

    logic                             tick;
    logic                             change;
    logic [1:0]                       sel_nxt;
    logic [DIGITS-1:0][COUNT_W-1:0]   h_nxt;
    logic [DIGITS-1:0]                v_nxt;
    logic [COUNT_W-1:0]               dec_in;
    logic [6:0]                       dec_out;
    logic [6:0]                       seg_d;
    logic [DIGITS-1:0]                an_d;

    assign tick   = &cnt;
    assign change = (x != h[0]);

    // Outputs are built from the post-update state so they trail it by exactly one cycle.
    always_comb begin
        sel_nxt = sel;
        h_nxt   = h;
        v_nxt   = v;
        if (tick) begin
            sel_nxt = sel + 2'd1;
        end
        if (change) begin
            h_nxt = {h[DIGITS-2:0], x};
            v_nxt = {v[DIGITS-2:0], 1'b1};
        end
        dec_in = h_nxt[sel_nxt];
        seg_d  = v_nxt[sel_nxt] ? dec_out : 7'h00;
        an_d   = DIGITS'(1) << sel_nxt;
    end

    seg7_decode u_decode (
        .hex (dec_in),
        .seg (dec_out)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt <= '0;
            sel <= '0;
            h   <= '0;
            v   <= DIGITS'(1);
            seg <= SEG_TABLE[0] ^ SEG_POL;
            an  <= DIGITS'(1) ^ AN_POL;
        end else begin
            cnt <= cnt + PRESCALE_WIDTH'(1);
            sel <= sel_nxt;
            h   <= h_nxt;
            v   <= v_nxt;
            seg <= seg_d ^ SEG_POL;
            an  <= an_d ^ AN_POL;
        end
    end

endmodule
